// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/response handshakes and RAM bus of the load/store unit
interface mem_lsu_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_fault;
    logic [2:0]            mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_data_in;
    logic [31:0]           mem_data_out;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_write_enable, mem_addr, mem_data_in
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_write_enable, mem_addr, mem_data_in
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit in front of a big-endian byte RAM
module mem_lsu #(
    parameter int MEM_BYTES  = 2048,
    parameter int ADDR_WIDTH = 32
) (
    input logic      clk,
    input logic      reset,
    mem_lsu_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

    logic [1:0]            state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  fault_q, fault_d;
    logic [2:0]            size;
    logic [ADDR_WIDTH:0]   end_addr;
    logic                  illegal, misaligned, out_of_range, fault;
    logic                  sign;
    logic [31:0]           load_data;

    // classify the incoming request; end address is one bit wider so it cannot wrap
    always_comb begin
        size         = bus.req_funct3[1:0] == 2'b10 ? 3'd4 : bus.req_funct3[1:0] == 2'b01 ? 3'd2 : 3'd1;
        end_addr     = {1'b0, bus.req_addr} + (ADDR_WIDTH + 1)'(size);
        illegal      = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3[2] && bus.req_funct3[1])
                       || (bus.req_write && bus.req_funct3[2]);
        misaligned   = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
                       || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
        out_of_range = end_addr > LIMIT;
        fault        = illegal || misaligned || out_of_range;
    end

    // pick and extend the addressed bytes; both B and H sign bits sit at bit 31 of the big-endian word
    always_comb begin
        sign      = ~funct3_q[2] & bus.mem_data_out[31];
        load_data = funct3_q[1] ? bus.mem_data_out
                  : funct3_q[0] ? {{16{sign}}, bus.mem_data_out[31:16]}
                  : {{24{sign}}, bus.mem_data_out[31:24]};
    end

    // FSM next state; RAM address/data only move when a good request is accepted
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        funct3_d   = funct3_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        if (state_q == IDLE) begin
            if (bus.req_valid) begin
                write_d    = bus.req_write;
                funct3_d   = bus.req_funct3;
                mem_addr_d = fault ? mem_addr_q : bus.req_addr;
                wdata_d    = fault ? wdata_q : bus.req_wdata;
                rdata_d    = 32'd0;
                fault_d    = fault;
                state_d    = fault ? RESP : ACCESS;
            end
        end else if (state_q == ACCESS) begin
            rdata_d = write_q ? 32'd0 : load_data;
            fault_d = 1'b0;
            state_d = RESP;
        end else if (state_q == RESP) begin
            state_d = bus.resp_ready ? IDLE : RESP;
        end else begin
            state_d = IDLE;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            funct3_q   <= 3'd0;
            mem_addr_q <= '0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            funct3_q   <= funct3_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.req_ready        = state_q == IDLE;
    assign bus.resp_valid       = state_q == RESP;
    assign bus.resp_rdata       = rdata_q;
    assign bus.resp_fault       = fault_q;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.mem_data_in      = wdata_q;
    assign bus.mem_write_enable = (state_q == ACCESS && write_q)
                                ? (funct3_q[1] ? 3'b001 : funct3_q[0] ? 3'b010 : 3'b100)
                                : 3'b000;
endmodule
